v_lane_writeback: RTL and testbench
===================================

// Module: v_lane_writeback
// PURPOSE
// - Consumer end of the vector lane result interface: captures the four 128-bit result chunks
//   (ALU or MUL set) when the lane array pulses done, then serialises them as 128-bit
//   write beats to the vector register file port with a valid/ready handshake.
// - Sits between the lane array and the VRF write port; one LMUL register group per operation.
// PARAMETERS
// - DATA_W      128  width of one result chunk / VRF write beat
// - NUM_CHUNKS  4    result chunks presented by the lanes (max beats per group)
// - VREG_W      5    VRF register index width (32 registers)
// PORTS
// - clk              in   1       clock, all state on rising edge
// - rst              in   1       asynchronous reset, active-high
// - done_in          in   1       lane array done pulse; result buses valid this cycle
// - is_mul           in   1       1: write MUL results, 0: write ALU results (sampled with done_in)
// - vd               in   VREG_W  destination base register (sampled with done_in)
// - lmul             in   3       group size code: 0->1 beat, 1->2, 2->4, >=3 clamped to 4
// - result_valu_1..4 in   DATA_W  ALU result chunks 1..4
// - result_vmul_1..4 in   DATA_W  MUL result chunks 1..4
// - wr_valid         out  1       write beat valid
// - wr_ready         in   1       VRF accepts beat when wr_valid && wr_ready
// - wr_vreg          out  VREG_W  target register = vd + beat index (mod 2^VREG_W)
// - wr_data          out  DATA_W  beat payload = captured chunk[beat index]
// - wr_be            out  DATA_W/8 byte enables
// - busy             out  1       1 while a group is buffered/being written
// - wb_done          out  1       one-cycle pulse after the last beat of a group is accepted
// - overflow         out  1       sticky: done_in arrived while unable to accept
// BEHAVIOUR
// - Reset (async, any time incl. mid-group): state IDLE, buffer/beat counter cleared,
//   wr_valid=0, wr_vreg=0, wr_data=0, wr_be=0, busy=0, wb_done=0, overflow=0. Partial group discarded.
// - FSM IDLE: done_in -> capture selected chunk set (is_mul mux) into NUM_CHUNKS x DATA_W buffer,
//   latch vd, nbeats from lmul; beat=0; go WRITE. No done_in -> stay, outputs low.
// - FSM WRITE: wr_valid=1; wr_data/wr_vreg/wr_be from beat. Handshake: beat advances only on
//   wr_valid&&wr_ready; payload held stable while wr_valid&&!wr_ready. Last beat accepted ->
//   wb_done=1 next cycle, go IDLE (wr_valid=0 that cycle).
// - Latency: done_in at cycle N -> wr_valid at N+1; with wr_ready tied 1, group of k beats
//   occupies cycles N+1..N+k, wb_done at N+k+1.
// - Back-to-back: done_in in the same cycle the last beat is accepted -> new group captured,
//   stay WRITE with beat=0, wb_done still pulses for the finished group; no bubble beat lost.
// - done_in in WRITE on any other cycle -> ignored, buffer untouched, overflow set (clears only on rst).
// - busy = (state==WRITE). vreg index wraps: vd=31, 4 beats -> 31,0,1,2.
// - Chunks beyond nbeats are never written.
// CONFIGURATION
// - Macro V_WB_TAIL_MASK_EN: defined -> extra inputs vsew[2:0] and vl[8:0] (sampled with done_in);
//   element bytes eb=1<<vsew (vsew 0..2; >2 treated as 2); byte k of beat b enabled iff
//   b*(DATA_W/8)+k < vl*eb; beats still issued for all nbeats (all-zero wr_be allowed).
// - Not defined -> no vsew/vl ports, wr_be = all ones whenever wr_valid=1.
// TESTING
// - lmul=0, is_mul=0, vd=5, ready=1, done_in pulse -> one beat vreg 5 = result_valu_1, wb_done 2 cycles later.
// - lmul=2, is_mul=1, vd=30, ready=1 -> beats vreg 30,31,0,1 carrying vmul_1..4 on 4 consecutive cycles.
// - lmul=1, ready low 3 cycles on beat 0 -> wr_data/wr_vreg stable, then 2 beats accepted, single wb_done.
// - done_in again during beat 1 of 4-beat group -> ignored, overflow=1, original data completes.
// - done_in coincident with last-beat accept -> new group's beat 0 next cycle, wb_done pulses once.
// - rst asserted mid-group -> outputs 0 immediately; (V_WB_TAIL_MASK_EN) vsew=2, vl=5, lmul=1 -> wr_be FFFF then 000F.

Source files
------------

// File: rtl/v_lane_writeback.sv
// v_lane_writeback: consumer end of the vector lane result interface.
// Captures the ALU or MUL result chunk set when the lane array pulses done_in,
// then streams the chunks as valid/ready write beats into the VRF write port,
// one LMUL register group per operation.
// Optional feature macro V_WB_TAIL_MASK_EN: adds vsew/vl inputs and drives
// per-byte tail masking on wr_be. When undefined, wr_be is all ones on every beat.
module v_lane_writeback #(
    parameter int DATA_W     = 128,
    parameter int NUM_CHUNKS = 4,
    parameter int VREG_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done_in,
    input  logic                  is_mul,
    input  logic [VREG_W-1:0]     vd,
    input  logic [2:0]            lmul,
`ifdef V_WB_TAIL_MASK_EN
    input  logic [2:0]            vsew,
    input  logic [8:0]            vl,
`endif
    input  logic [DATA_W-1:0]     result_valu_1,
    input  logic [DATA_W-1:0]     result_valu_2,
    input  logic [DATA_W-1:0]     result_valu_3,
    input  logic [DATA_W-1:0]     result_valu_4,
    input  logic [DATA_W-1:0]     result_vmul_1,
    input  logic [DATA_W-1:0]     result_vmul_2,
    input  logic [DATA_W-1:0]     result_vmul_3,
    input  logic [DATA_W-1:0]     result_vmul_4,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [VREG_W-1:0]     wr_vreg,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   wr_be,
    output logic                  busy,
    output logic                  wb_done,
    output logic                  overflow
);

    localparam int BE_W   = DATA_W / 8;
    localparam int BEAT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   buffer [NUM_CHUNKS];
    logic [VREG_W-1:0]   vd_q;
    logic [BEAT_W-1:0]   last_q;
    logic [BEAT_W-1:0]   beat;

    logic [DATA_W-1:0]   sel_chunk [NUM_CHUNKS];
    logic [BEAT_W-1:0]   lmul_last;
    logic [BEAT_W-1:0]   beat_nx;
    logic                accept;
    logic                last_accept;
    logic                start;
    logic [BE_W-1:0]     next_be;

`ifdef V_WB_TAIL_MASK_EN
    logic [11:0]         total_q;
    logic [11:0]         total_in;
    logic [1:0]          vsew_c;

    // Byte k of beat b is live while its absolute byte offset is below vl*eb.
    function automatic logic [BE_W-1:0] tail_be(input logic [BEAT_W-1:0] b,
                                                input logic [11:0] total);
        logic [BE_W-1:0] be;
        be = '0;
        for (int k = 0; k < BE_W; k++) begin
            be[k] = ((int'(b) * BE_W + k) < int'(total));
        end
        return be;
    endfunction

    // Element size clamps at 4 bytes; total live bytes of the group is vl << vsew.
    always_comb begin
        vsew_c   = (vsew > 3'd2) ? 2'd2 : vsew[1:0];
        total_in = 12'(vl) << vsew_c;
    end
`endif

    // Pick the chunk set the lanes are reporting on this done pulse.
    always_comb begin
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            sel_chunk[i] = '0;
        end
        sel_chunk[0] = is_mul ? result_vmul_1 : result_valu_1;
        sel_chunk[1] = is_mul ? result_vmul_2 : result_valu_2;
        sel_chunk[2] = is_mul ? result_vmul_3 : result_valu_3;
        sel_chunk[3] = is_mul ? result_vmul_4 : result_valu_4;
    end

    // Decode the group size into the index of the final beat; large codes clamp to the full set.
    always_comb begin
        case (lmul)
            3'd0:    lmul_last = BEAT_W'(0);
            3'd1:    lmul_last = BEAT_W'(1);
            default: lmul_last = BEAT_W'(NUM_CHUNKS - 1);
        endcase
    end

    // Handshake decode: a new group may start from idle or exactly as the last beat leaves.
    always_comb begin
        accept      = wr_valid && wr_ready;
        last_accept = accept && (state == WRITE) && (beat == last_q);
        start       = done_in && ((state == IDLE) || last_accept);
        beat_nx     = beat + 1'b1;
    end

    // Byte enables for whichever beat gets presented after this edge.
    always_comb begin
`ifdef V_WB_TAIL_MASK_EN
        next_be = start ? tail_be('0, total_in) : tail_be(beat_nx, total_q);
`else
        next_be = '1;
`endif
    end

    // Writeback FSM with registered beat outputs; a partial group is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                buffer[i] <= '0;
            end
            vd_q     <= '0;
            last_q   <= '0;
            beat     <= '0;
`ifdef V_WB_TAIL_MASK_EN
            total_q  <= '0;
`endif
            wr_valid <= 1'b0;
            wr_vreg  <= '0;
            wr_data  <= '0;
            wr_be    <= '0;
            wb_done  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wb_done <= last_accept;
            if (done_in && (state == WRITE) && !last_accept) begin
                overflow <= 1'b1;
            end
            if (start) begin
                state  <= WRITE;
                for (int i = 0; i < NUM_CHUNKS; i++) begin
                    buffer[i] <= sel_chunk[i];
                end
                vd_q   <= vd;
                last_q <= lmul_last;
                beat   <= '0;
`ifdef V_WB_TAIL_MASK_EN
                total_q <= total_in;
`endif
                wr_valid <= 1'b1;
                wr_vreg  <= vd;
                wr_data  <= sel_chunk[0];
                wr_be    <= next_be;
            end else if ((state == WRITE) && accept) begin
                if (beat == last_q) begin
                    state    <= IDLE;
                    beat     <= '0;
                    wr_valid <= 1'b0;
                    wr_vreg  <= '0;
                    wr_data  <= '0;
                    wr_be    <= '0;
                end else begin
                    beat    <= beat_nx;
                    wr_vreg <= vd_q + VREG_W'(beat_nx);
                    wr_data <= buffer[beat_nx];
                    wr_be   <= next_be;
                end
            end
        end
    end

    assign busy = (state == WRITE);

endmodule

// File: tb/tb_v_lane_writeback.sv
// Testbench for v_lane_writeback: table of single-group vectors plus
// hand-written sequences for backpressure, overflow, back-to-back and reset.
// Tail-mask checks are compiled in when V_WB_TAIL_MASK_EN is defined.
module tb_v_lane_writeback;

    localparam int DATA_W = 128;
    localparam int VREG_W = 5;
    localparam int BE_W   = DATA_W / 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                done_in;
    logic                is_mul;
    logic [VREG_W-1:0]   vd;
    logic [2:0]          lmul;
`ifdef V_WB_TAIL_MASK_EN
    logic [2:0]          vsew;
    logic [8:0]          vl;
`endif
    logic [DATA_W-1:0]   valu_c [4];
    logic [DATA_W-1:0]   vmul_c [4];
    logic                wr_valid;
    logic                wr_ready;
    logic [VREG_W-1:0]   wr_vreg;
    logic [DATA_W-1:0]   wr_data;
    logic [BE_W-1:0]     wr_be;
    logic                busy;
    logic                wb_done;
    logic                overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic              is_mul;
        logic [VREG_W-1:0] vd;
        logic [2:0]        lmul;
        int                beats;
    } vec_t;

    vec_t vecs [6];

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    v_lane_writeback #(
        .DATA_W     (DATA_W),
        .NUM_CHUNKS (4),
        .VREG_W     (VREG_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .done_in       (done_in),
        .is_mul        (is_mul),
        .vd            (vd),
        .lmul          (lmul),
`ifdef V_WB_TAIL_MASK_EN
        .vsew          (vsew),
        .vl            (vl),
`endif
        .result_valu_1 (valu_c[0]),
        .result_valu_2 (valu_c[1]),
        .result_valu_3 (valu_c[2]),
        .result_valu_4 (valu_c[3]),
        .result_vmul_1 (vmul_c[0]),
        .result_vmul_2 (vmul_c[1]),
        .result_vmul_3 (vmul_c[2]),
        .result_vmul_4 (vmul_c[3]),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_vreg       (wr_vreg),
        .wr_data       (wr_data),
        .wr_be         (wr_be),
        .busy          (busy),
        .wb_done       (wb_done),
        .overflow      (overflow)
    );

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle done pulse; returns one cycle later, when beat 0 should be showing.
    task automatic applyStimulus(input logic m, input logic [VREG_W-1:0] v, input logic [2:0] l);
        done_in = 1'b1;
        is_mul  = m;
        vd      = v;
        lmul    = l;
        step();
        done_in = 1'b0;
    endtask

    task automatic checkBeat(input string tag, input logic m, input logic [VREG_W-1:0] v,
                             input int b);
        logic [VREG_W-1:0] exp_vreg;
        exp_vreg = v + VREG_W'(b);
        checkOutput({tag, ".valid"}, DATA_W'(wr_valid), DATA_W'(1));
        checkOutput({tag, ".vreg"}, DATA_W'(wr_vreg), DATA_W'(exp_vreg));
        checkOutput({tag, ".data"}, wr_data, m ? vmul_c[b] : valu_c[b]);
        checkOutput({tag, ".be"}, DATA_W'(wr_be), DATA_W'({BE_W{1'b1}}));
        checkOutput({tag, ".busy"}, DATA_W'(busy), DATA_W'(1));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            valu_c[i] = {4{32'hA5A5_0000 + 32'(i)}};
            vmul_c[i] = {4{32'h5A5A_0100 + 32'(i)}};
        end
        vecs[0] = '{1'b0, 5'd5,  3'd0, 1};
        vecs[1] = '{1'b1, 5'd30, 3'd2, 4};
        vecs[2] = '{1'b0, 5'd12, 3'd1, 2};
        vecs[3] = '{1'b1, 5'd31, 3'd3, 4};
        vecs[4] = '{1'b0, 5'd0,  3'd7, 4};
        vecs[5] = '{1'b1, 5'd7,  3'd1, 2};

        rst      = 1'b1;
        done_in  = 1'b0;
        is_mul   = 1'b0;
        vd       = '0;
        lmul     = '0;
        wr_ready = 1'b1;
`ifdef V_WB_TAIL_MASK_EN
        vsew     = 3'd2;
        vl       = 9'd256;
`endif
        step();
        step();
        checkOutput("reset.valid", DATA_W'(wr_valid), '0);
        checkOutput("reset.vreg", DATA_W'(wr_vreg), '0);
        checkOutput("reset.data", wr_data, '0);
        checkOutput("reset.be", DATA_W'(wr_be), '0);
        checkOutput("reset.busy", DATA_W'(busy), '0);
        checkOutput("reset.wb_done", DATA_W'(wb_done), '0);
        checkOutput("reset.overflow", DATA_W'(overflow), '0);
        rst = 1'b0;
        step();

        // Table-driven single groups with ready held high.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].is_mul, vecs[i].vd, vecs[i].lmul);
            for (int b = 0; b < vecs[i].beats; b++) begin
                checkBeat($sformatf("vec%0d.beat%0d", i, b), vecs[i].is_mul, vecs[i].vd, b);
                checkOutput($sformatf("vec%0d.beat%0d.wb_done", i, b), DATA_W'(wb_done), '0);
                if (b < vecs[i].beats - 1) step();
            end
            step();
            checkOutput($sformatf("vec%0d.wb_done", i), DATA_W'(wb_done), DATA_W'(1));
            checkOutput($sformatf("vec%0d.idle_valid", i), DATA_W'(wr_valid), '0);
            checkOutput($sformatf("vec%0d.idle_busy", i), DATA_W'(busy), '0);
            step();
            checkOutput($sformatf("vec%0d.wb_done_clr", i), DATA_W'(wb_done), '0);
        end
        checkOutput("table.overflow", DATA_W'(overflow), '0);

        // Backpressure: ready low for three cycles on beat 0 of a 2-beat group.
        wr_ready = 1'b0;
        applyStimulus(1'b0, 5'd9, 3'd1);
        for (int c = 0; c < 3; c++) begin
            checkBeat($sformatf("bp.hold%0d", c), 1'b0, 5'd9, 0);
            checkOutput($sformatf("bp.hold%0d.wb_done", c), DATA_W'(wb_done), '0);
            step();
        end
        wr_ready = 1'b1;
        checkBeat("bp.beat0", 1'b0, 5'd9, 0);
        step();
        checkBeat("bp.beat1", 1'b0, 5'd9, 1);
        checkOutput("bp.beat1.wb_done", DATA_W'(wb_done), '0);
        step();
        checkOutput("bp.wb_done", DATA_W'(wb_done), DATA_W'(1));
        checkOutput("bp.idle_valid", DATA_W'(wr_valid), '0);
        step();
        checkOutput("bp.wb_done_clr", DATA_W'(wb_done), '0);

        // Back-to-back: new done coincident with the last beat of the running group.
        applyStimulus(1'b0, 5'd3, 3'd1);
        checkBeat("b2b.a0", 1'b0, 5'd3, 0);
        step();
        checkBeat("b2b.a1", 1'b0, 5'd3, 1);
        done_in = 1'b1;
        is_mul  = 1'b1;
        vd      = 5'd10;
        lmul    = 3'd0;
        step();
        done_in = 1'b0;
        checkBeat("b2b.b0", 1'b1, 5'd10, 0);
        checkOutput("b2b.a_wb_done", DATA_W'(wb_done), DATA_W'(1));
        step();
        checkOutput("b2b.b_wb_done", DATA_W'(wb_done), DATA_W'(1));
        checkOutput("b2b.idle_valid", DATA_W'(wr_valid), '0);
        step();
        checkOutput("b2b.wb_done_clr", DATA_W'(wb_done), '0);
        checkOutput("b2b.overflow", DATA_W'(overflow), '0);

        // Overflow: a done pulse during beat 1 of a 4-beat group is dropped.
        applyStimulus(1'b0, 5'd20, 3'd2);
        checkBeat("ovf.beat0", 1'b0, 5'd20, 0);
        step();
        checkBeat("ovf.beat1", 1'b0, 5'd20, 1);
        done_in = 1'b1;
        is_mul  = 1'b1;
        vd      = 5'd3;
        lmul    = 3'd0;
        step();
        done_in = 1'b0;
        checkBeat("ovf.beat2", 1'b0, 5'd20, 2);
        checkOutput("ovf.flag", DATA_W'(overflow), DATA_W'(1));
        step();
        checkBeat("ovf.beat3", 1'b0, 5'd20, 3);
        step();
        checkOutput("ovf.wb_done", DATA_W'(wb_done), DATA_W'(1));
        checkOutput("ovf.idle_valid", DATA_W'(wr_valid), '0);
        step();
        checkOutput("ovf.no_restart", DATA_W'(wr_valid), '0);
        checkOutput("ovf.sticky", DATA_W'(overflow), DATA_W'(1));

        // Asynchronous reset in the middle of a group clears outputs without a clock edge.
        applyStimulus(1'b1, 5'd17, 3'd2);
        checkBeat("rst.beat0", 1'b1, 5'd17, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst.valid", DATA_W'(wr_valid), '0);
        checkOutput("rst.vreg", DATA_W'(wr_vreg), '0);
        checkOutput("rst.data", wr_data, '0);
        checkOutput("rst.be", DATA_W'(wr_be), '0);
        checkOutput("rst.busy", DATA_W'(busy), '0);
        checkOutput("rst.overflow", DATA_W'(overflow), '0);
        step();
        rst = 1'b0;
        step();
        checkOutput("rst.after_valid", DATA_W'(wr_valid), '0);

`ifdef V_WB_TAIL_MASK_EN
        // Tail mask: 32-bit elements, vl=5 -> 20 live bytes across two beats.
        vsew = 3'd2;
        vl   = 9'd5;
        applyStimulus(1'b0, 5'd1, 3'd1);
        checkOutput("tail.be0", DATA_W'(wr_be), DATA_W'(16'hFFFF));
        step();
        checkOutput("tail.be1", DATA_W'(wr_be), DATA_W'(16'h000F));
        checkOutput("tail.valid1", DATA_W'(wr_valid), DATA_W'(1));
        step();
        checkOutput("tail.wb_done", DATA_W'(wb_done), DATA_W'(1));
        vl = 9'd256;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
